// File: rtl/z80_idx_bitop_seq_pkg.sv
// Shared definitions for the DD/FD CB d bit-operation sequencer:
// FSM states, op-class codes, M-cycle type codes, F-register bit
// positions and default T-state extensions.
package z80_idx_bitop_seq_pkg;

  // M-cycle type codes understood by the core's cycle engine.
  localparam logic [2:0] CYCLE_M1       = 3'd1;
  localparam logic [2:0] CYCLE_RDWR_MEM = 3'd2;

  // F-register bit positions.
  localparam int unsigned FLAG_C_NUM  = 0;
  localparam int unsigned FLAG_N_NUM  = 1;
  localparam int unsigned FLAG_PV_NUM = 2;
  localparam int unsigned FLAG_3_NUM  = 3;
  localparam int unsigned FLAG_H_NUM  = 4;
  localparam int unsigned FLAG_5_NUM  = 5;
  localparam int unsigned FLAG_Z_NUM  = 6;
  localparam int unsigned FLAG_S_NUM  = 7;

  // Default extra T-states: opcode read carries the EA add (3+2),
  // operand read is 3+1.
  localparam int unsigned T_OP_EXTRA_DEF = 2;
  localparam int unsigned T_RD_EXTRA_DEF = 1;

  // Op class taken from op[7:6] of the CB-page opcode.
  typedef enum logic [1:0] {
    OPC_ROT = 2'b00,
    OPC_BIT = 2'b01,
    OPC_RES = 2'b10,
    OPC_SET = 2'b11
  } opc_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CB,
    ST_DISP,
    ST_OP,
    ST_RD,
    ST_WR,
    ST_FIN
  } state_e;

endpackage

// File: rtl/z80_idx_bitop_seq_alu.sv
// Combinational bit-op datapath for BIT/RES/SET b,(IX/IY+d).
// Optional macro Z80_MEMPTR_FLAGS_EN: BIT takes F5/F3 from EA[13]/EA[11]
// (silicon WZ behaviour) instead of passing them through from F.
module z80_bitop_alu
  import z80_idx_bitop_seq_pkg::*;
(
  input  opc_e        opc_i,
  input  logic [2:0]  b_i,
  input  logic [7:0]  data_i,
  input  logic [7:0]  f_i,
  input  logic [15:0] ea_i,
  output logic [7:0]  wdata_o,
  output logic [7:0]  f_o
);

  logic [7:0] mask;
  logic       ea_unused;

  assign ea_unused = ^ea_i;

  // Write-back data for RES/SET and flag result for BIT; F passes through otherwise.
  always_comb begin
    mask    = 8'h01 << b_i;
    wdata_o = data_i;
    f_o     = f_i;
    case (opc_i)
      OPC_RES: wdata_o = data_i & ~mask;
      OPC_SET: wdata_o = data_i | mask;
      OPC_BIT: begin
        f_o[FLAG_S_NUM]  = (b_i == 3'd7) & data_i[7];
        f_o[FLAG_Z_NUM]  = ~data_i[b_i];
        f_o[FLAG_PV_NUM] = ~data_i[b_i];
        f_o[FLAG_H_NUM]  = 1'b1;
        f_o[FLAG_N_NUM]  = 1'b0;
`ifdef Z80_MEMPTR_FLAGS_EN
        f_o[FLAG_5_NUM]  = ea_i[13];
        f_o[FLAG_3_NUM]  = ea_i[11];
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/z80_idx_bitop_seq.sv
// Execution sequencer for DD/FD CB d op (BIT/RES/SET b,(IX/IY+d)).
// Runs CB fetch, displacement read, opcode read, operand read and the
// RES/SET write-back, then returns F and IP+4 with a one-cycle done.
// Optional macro Z80_MEMPTR_FLAGS_EN (handled in z80_bitop_alu).
module z80_idx_bitop_seq
  import z80_idx_bitop_seq_pkg::*;
#(
  parameter int unsigned T_OP_EXTRA = T_OP_EXTRA_DEF,
  parameter int unsigned T_RD_EXTRA = T_RD_EXTRA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        iy,
  input  logic [15:0] reg_ix_in,
  input  logic [15:0] reg_iy_in,
  input  logic [7:0]  reg_f_in,
  input  logic [15:0] reg_ip_in,
  output logic        mcyc_valid,
  output logic [2:0]  mcyc_type,
  output logic        mcyc_write,
  output logic [15:0] mcyc_addr,
  output logic [7:0]  mcyc_wdata,
  output logic [2:0]  mcyc_extra_t,
  input  logic        mcyc_done,
  input  logic [7:0]  mcyc_rdata,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [7:0]  reg_f_out,
  output logic [15:0] reg_ip_out
);

  state_e      state_q;
  logic [15:0] base_q;
  logic [15:0] ip_q;
  logic [15:0] ea_q;
  logic [7:0]  f_q;
  logic [7:0]  d_q;
  logic [7:0]  data_q;
  logic [4:0]  op_q;       // op[7:3]: class and bit index
  logic [7:0]  alu_data;
  logic [7:0]  alu_wdata;
  logic [7:0]  alu_f;
  logic [15:0] ea_d;
  opc_e        opc;

  assign opc = opc_e'(op_q[4:3]);

  // Operand is taken straight off the bus on the RD completion cycle so the
  // BIT flags can be registered together with done.
  always_comb begin
    alu_data = (state_q == ST_RD) ? mcyc_rdata : data_q;
    ea_d     = base_q + {{8{d_q[7]}}, d_q};
  end

  z80_bitop_alu u_alu (
    .opc_i   (opc),
    .b_i     (op_q[2:0]),
    .data_i  (alu_data),
    .f_i     (f_q),
    .ea_i    (ea_q),
    .wdata_o (alu_wdata),
    .f_o     (alu_f)
  );

  // Sequencer FSM: each state issues its request with valid low on entry,
  // then completes on mcyc_done and advances with valid dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      ip_q         <= '0;
      ea_q         <= '0;
      f_q          <= '0;
      d_q          <= '0;
      data_q       <= '0;
      op_q         <= '0;
      mcyc_valid   <= 1'b0;
      mcyc_type    <= '0;
      mcyc_write   <= 1'b0;
      mcyc_addr    <= '0;
      mcyc_wdata   <= '0;
      mcyc_extra_t <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      reg_f_out    <= '0;
      reg_ip_out   <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q  <= iy ? reg_iy_in : reg_ix_in;
            f_q     <= reg_f_in;
            ip_q    <= reg_ip_in;
            busy    <= 1'b1;
            state_q <= ST_CB;
          end
        end
        ST_CB: begin
          if (!mcyc_valid) begin
            mcyc_valid   <= 1'b1;
            mcyc_type    <= CYCLE_M1;
            mcyc_write   <= 1'b0;
            mcyc_addr    <= ip_q + 16'd1;
            mcyc_wdata   <= '0;
            mcyc_extra_t <= '0;
          end else if (mcyc_done) begin
            mcyc_valid <= 1'b0;
            if (mcyc_rdata == 8'hCB) begin
              state_q <= ST_DISP;
            end else begin
              state_q    <= ST_FIN;
              done       <= 1'b1;
              illegal    <= 1'b1;
              reg_f_out  <= f_q;
              reg_ip_out <= ip_q + 16'd4;
            end
          end
        end
        ST_DISP: begin
          if (!mcyc_valid) begin
            mcyc_valid   <= 1'b1;
            mcyc_type    <= CYCLE_RDWR_MEM;
            mcyc_write   <= 1'b0;
            mcyc_addr    <= ip_q + 16'd2;
            mcyc_wdata   <= '0;
            mcyc_extra_t <= '0;
          end else if (mcyc_done) begin
            mcyc_valid <= 1'b0;
            d_q        <= mcyc_rdata;
            state_q    <= ST_OP;
          end
        end
        ST_OP: begin
          if (!mcyc_valid) begin
            mcyc_valid   <= 1'b1;
            mcyc_type    <= CYCLE_RDWR_MEM;
            mcyc_write   <= 1'b0;
            mcyc_addr    <= ip_q + 16'd3;
            mcyc_wdata   <= '0;
            mcyc_extra_t <= 3'(T_OP_EXTRA);
          end else if (mcyc_done) begin
            mcyc_valid <= 1'b0;
            op_q       <= mcyc_rdata[7:3];
            ea_q       <= ea_d;
            state_q    <= ST_RD;
          end
        end
        ST_RD: begin
          if (!mcyc_valid) begin
            mcyc_valid   <= 1'b1;
            mcyc_type    <= CYCLE_RDWR_MEM;
            mcyc_write   <= 1'b0;
            mcyc_addr    <= ea_q;
            mcyc_wdata   <= '0;
            mcyc_extra_t <= 3'(T_RD_EXTRA);
          end else if (mcyc_done) begin
            mcyc_valid <= 1'b0;
            data_q     <= mcyc_rdata;
            unique case (opc)
              OPC_BIT: begin
                state_q    <= ST_FIN;
                done       <= 1'b1;
                reg_f_out  <= alu_f;
                reg_ip_out <= ip_q + 16'd4;
              end
              OPC_RES, OPC_SET: begin
                state_q <= ST_WR;
              end
              default: begin
                state_q    <= ST_FIN;
                done       <= 1'b1;
                illegal    <= 1'b1;
                reg_f_out  <= f_q;
                reg_ip_out <= ip_q + 16'd4;
              end
            endcase
          end
        end
        ST_WR: begin
          if (!mcyc_valid) begin
            mcyc_valid   <= 1'b1;
            mcyc_type    <= CYCLE_RDWR_MEM;
            mcyc_write   <= 1'b1;
            mcyc_addr    <= ea_q;
            mcyc_wdata   <= alu_wdata;
            mcyc_extra_t <= '0;
          end else if (mcyc_done) begin
            mcyc_valid <= 1'b0;
            mcyc_write <= 1'b0;
            state_q    <= ST_FIN;
            done       <= 1'b1;
            reg_f_out  <= f_q;
            reg_ip_out <= ip_q + 16'd4;
          end
        end
        ST_FIN: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_idx_bitop_seq.sv
// Self-checking bench for z80_idx_bitop_seq: a memory responder pops the
// expected M-cycle queue on every completed request; scenario tasks check
// retirement results against hand-derived constants.
module tb_z80_idx_bitop_seq;
  import z80_idx_bitop_seq_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        iy;
  logic [15:0] reg_ix_in;
  logic [15:0] reg_iy_in;
  logic [7:0]  reg_f_in;
  logic [15:0] reg_ip_in;
  logic        mcyc_valid;
  logic [2:0]  mcyc_type;
  logic        mcyc_write;
  logic [15:0] mcyc_addr;
  logic [7:0]  mcyc_wdata;
  logic [2:0]  mcyc_extra_t;
  logic        mcyc_done;
  logic [7:0]  mcyc_rdata;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [7:0]  reg_f_out;
  logic [15:0] reg_ip_out;

  typedef struct {
    logic [2:0]  typ;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [2:0]  ext;
  } req_t;

  req_t        exp_q[$];
  logic [7:0]  mem [0:65535];
  int          n_checks;
  int          n_fail;
  int          cyc;
  int          last_resp_cyc;
  int          resp_lat;
  logic        stall_en;
  logic [15:0] stall_addr;

  z80_idx_bitop_seq dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .iy           (iy),
    .reg_ix_in    (reg_ix_in),
    .reg_iy_in    (reg_iy_in),
    .reg_f_in     (reg_f_in),
    .reg_ip_in    (reg_ip_in),
    .mcyc_valid   (mcyc_valid),
    .mcyc_type    (mcyc_type),
    .mcyc_write   (mcyc_write),
    .mcyc_addr    (mcyc_addr),
    .mcyc_wdata   (mcyc_wdata),
    .mcyc_extra_t (mcyc_extra_t),
    .mcyc_done    (mcyc_done),
    .mcyc_rdata   (mcyc_rdata),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal),
    .reg_f_out    (reg_f_out),
    .reg_ip_out   (reg_ip_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory responder / scoreboard consumer.
  initial begin : responder
    int   cnt;
    req_t e;
    cnt        = 0;
    mcyc_done  = 1'b0;
    mcyc_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      mcyc_done = 1'b0;
      if (!mcyc_valid || reset) begin
        cnt = 0;
      end else if (stall_en && !mcyc_write && mcyc_addr == stall_addr) begin
        cnt = 0;
      end else if (cnt < resp_lat) begin
        cnt++;
      end else begin
        cnt = 0;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_req: got type=%0d wr=%b addr=%h wdata=%h ext=%0d, expected no request",
                   mcyc_type, mcyc_write, mcyc_addr, mcyc_wdata, mcyc_extra_t);
        end else begin
          e = exp_q.pop_front();
          if (mcyc_type !== e.typ || mcyc_write !== e.wr || mcyc_addr !== e.addr ||
              mcyc_extra_t !== e.ext || (e.wr && mcyc_wdata !== e.wdata)) begin
            n_fail++;
            $display("FAIL mcyc_req: got type=%0d wr=%b addr=%h wdata=%h ext=%0d, expected type=%0d wr=%b addr=%h wdata=%h ext=%0d",
                     mcyc_type, mcyc_write, mcyc_addr, mcyc_wdata, mcyc_extra_t,
                     e.typ, e.wr, e.addr, e.wdata, e.ext);
          end
        end
        if (mcyc_write) mem[mcyc_addr] = mcyc_wdata;
        else            mcyc_rdata = mem[mcyc_addr];
        mcyc_done     = 1'b1;
        last_resp_cyc = cyc;
      end
    end
  end

  // Loads code bytes, pushes the expected M-cycles, starts the DUT and waits
  // (bounded) for done. With glitch set, a second start with different
  // register inputs is pulsed while the sequencer is busy.
  task automatic run_insn(input logic use_iy, input logic [15:0] ix, input logic [15:0] iyv,
                          input logic [15:0] ip, input logic [7:0] f,
                          input logic [7:0] b1, input logic [7:0] d, input logic [7:0] op,
                          input logic glitch,
                          output logic o_ill, output logic [7:0] o_f, output logic [15:0] o_ip,
                          output logic o_to, output int o_done_cyc);
    logic [15:0] base;
    logic [15:0] ea;
    logic [7:0]  m;
    logic [7:0]  mask;
    req_t        r;
    mem[ip + 16'd1] = b1;
    mem[ip + 16'd2] = d;
    mem[ip + 16'd3] = op;
    base = use_iy ? iyv : ix;
    ea   = base + {{8{d[7]}}, d};
    r = '{typ: CYCLE_M1, wr: 1'b0, addr: ip + 16'd1, wdata: 8'h00, ext: 3'd0};
    exp_q.push_back(r);
    if (b1 == 8'hCB) begin
      r = '{typ: CYCLE_RDWR_MEM, wr: 1'b0, addr: ip + 16'd2, wdata: 8'h00, ext: 3'd0};
      exp_q.push_back(r);
      r = '{typ: CYCLE_RDWR_MEM, wr: 1'b0, addr: ip + 16'd3, wdata: 8'h00, ext: 3'd2};
      exp_q.push_back(r);
      r = '{typ: CYCLE_RDWR_MEM, wr: 1'b0, addr: ea, wdata: 8'h00, ext: 3'd1};
      exp_q.push_back(r);
      if (op[7]) begin
        m    = mem[ea];
        mask = 8'h01 << op[5:3];
        r = '{typ: CYCLE_RDWR_MEM, wr: 1'b1, addr: ea,
              wdata: (op[6] ? (m | mask) : (m & ~mask)), ext: 3'd0};
        exp_q.push_back(r);
      end
    end
    @(posedge clk); #1;
    iy = use_iy; reg_ix_in = ix; reg_iy_in = iyv; reg_ip_in = ip; reg_f_in = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (glitch) begin
      @(posedge clk); #1;
      iy = ~use_iy; reg_ix_in = 16'hAAAA; reg_iy_in = 16'h5555;
      reg_ip_in = 16'h7777; reg_f_in = 8'hFF;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    o_to = 1'b1; o_ill = 1'b0; o_f = 8'h00; o_ip = 16'h0000; o_done_cyc = 0;
    for (int k = 0; k < 200; k++) begin
      if (done) begin
        o_to = 1'b0; o_ill = illegal; o_f = reg_f_out; o_ip = reg_ip_out; o_done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({mcyc_valid, busy, done, illegal} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got valid/busy/done/illegal=%b, expected 0000", {mcyc_valid, busy, done, illegal});
    end
    n_checks++;
    if ({reg_f_out, reg_ip_out} !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_regs: got f=%h ip=%h, expected f=00 ip=0000", reg_f_out, reg_ip_out);
    end
    n_checks++;
    if ({mcyc_type, mcyc_write, mcyc_addr, mcyc_wdata, mcyc_extra_t} !== '0) begin
      n_fail++;
      $display("FAIL reset_mcyc: got type=%0d wr=%b addr=%h wdata=%h ext=%0d, expected all zero",
               mcyc_type, mcyc_write, mcyc_addr, mcyc_wdata, mcyc_extra_t);
    end
    reset = 1'b0;
  endtask

  task automatic test_bit_neg_disp();
    logic ill; logic [7:0] f; logic [15:0] ip; logic to; int dc;
    logic [7:0] ef;
`ifdef Z80_MEMPTR_FLAGS_EN
    ef = 8'h5D;
`else
    ef = 8'h7D;
`endif
    resp_lat = 1;
    mem[16'h0FFE] = 8'h00;
    run_insn(1'b0, 16'h1000, 16'h0000, 16'h0100, 8'h29, 8'hCB, 8'hFE, 8'h46, 1'b0, ill, f, ip, to, dc);
    n_checks++;
    if (to || ill !== 1'b0 || f !== ef || ip !== 16'h0104) begin
      n_fail++;
      $display("FAIL bit0_neg_disp: got timeout=%b illegal=%b f=%h ip=%h, expected timeout=0 illegal=0 f=%h ip=0104", to, ill, f, ip, ef);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bit0_reqs_left: got %0d outstanding, expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_set_iy();
    logic ill; logic [7:0] f; logic [15:0] ip; logic to; int dc;
    resp_lat = 0;
    mem[16'h2005] = 8'h01;
    run_insn(1'b1, 16'h3000, 16'h2000, 16'h0400, 8'hA5, 8'hCB, 8'h05, 8'hFE, 1'b0, ill, f, ip, to, dc);
    n_checks++;
    if (to || ill !== 1'b0 || f !== 8'hA5 || ip !== 16'h0404) begin
      n_fail++;
      $display("FAIL set7_iy: got timeout=%b illegal=%b f=%h ip=%h, expected timeout=0 illegal=0 f=a5 ip=0404", to, ill, f, ip);
    end
    n_checks++;
    if (mem[16'h2005] !== 8'h81) begin
      n_fail++;
      $display("FAIL set7_mem: got %h, expected 81", mem[16'h2005]);
    end
    n_checks++;
    if (dc - last_resp_cyc != 1) begin
      n_fail++;
      $display("FAIL set7_done_lat: got %0d cycles after write done, expected 1", dc - last_resp_cyc);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL set7_reqs_left: got %0d outstanding, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b busy=%b one cycle later, expected 0 0", done, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_res_wrap();
    logic ill; logic [7:0] f; logic [15:0] ip; logic to; int dc;
    resp_lat = 2;
    mem[16'h0000] = 8'hFF;
    run_insn(1'b0, 16'hFFFF, 16'h0000, 16'h4000, 8'h12, 8'hCB, 8'h01, 8'h9E, 1'b0, ill, f, ip, to, dc);
    n_checks++;
    if (to || ill !== 1'b0 || f !== 8'h12 || ip !== 16'h4004) begin
      n_fail++;
      $display("FAIL res3_wrap: got timeout=%b illegal=%b f=%h ip=%h, expected timeout=0 illegal=0 f=12 ip=4004", to, ill, f, ip);
    end
    n_checks++;
    if (mem[16'h0000] !== 8'hF7 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL res3_mem: got mem=%h outstanding=%0d, expected mem=f7 outstanding=0", mem[16'h0000], exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_bit_flags();
    logic ill; logic [7:0] f; logic [15:0] ip; logic to; int dc;
    logic [7:0] ef;
`ifdef Z80_MEMPTR_FLAGS_EN
    ef = 8'hB8;
`else
    ef = 8'h90;
`endif
    resp_lat = 1;
    mem[16'h2900] = 8'h80;
    run_insn(1'b0, 16'h28FF, 16'h0000, 16'h0800, 8'h02, 8'hCB, 8'h01, 8'h7E, 1'b0, ill, f, ip, to, dc);
    n_checks++;
    if (to || ill !== 1'b0 || f !== ef || ip !== 16'h0804 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bit7_flags: got timeout=%b illegal=%b f=%h ip=%h left=%0d, expected timeout=0 illegal=0 f=%h ip=0804 left=0",
               to, ill, f, ip, exp_q.size(), ef);
    end
    exp_q.delete();
    mem[16'hFF80] = 8'h02;
    run_insn(1'b0, 16'h0000, 16'h0000, 16'h0300, 8'hFF, 8'hCB, 8'h80, 8'h4E, 1'b0, ill, f, ip, to, dc);
    n_checks++;
    if (to || ill !== 1'b0 || f !== 8'h39 || ip !== 16'h0304 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bit1_ea_wrap: got timeout=%b illegal=%b f=%h ip=%h left=%0d, expected timeout=0 illegal=0 f=39 ip=0304 left=0",
               to, ill, f, ip, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_illegal();
    logic ill; logic [7:0] f; logic [15:0] ip; logic to; int dc;
    resp_lat = 0;
    mem[16'h1000] = 8'h5A;
    run_insn(1'b0, 16'h1000, 16'h0000, 16'h0700, 8'hC3, 8'hCB, 8'h00, 8'h06, 1'b0, ill, f, ip, to, dc);
    n_checks++;
    if (to || ill !== 1'b1 || f !== 8'hC3 || ip !== 16'h0704) begin
      n_fail++;
      $display("FAIL illegal_rot: got timeout=%b illegal=%b f=%h ip=%h, expected timeout=0 illegal=1 f=c3 ip=0704", to, ill, f, ip);
    end
    n_checks++;
    if (mem[16'h1000] !== 8'h5A || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL illegal_rot_nowrite: got mem=%h left=%0d, expected mem=5a left=0", mem[16'h1000], exp_q.size());
    end
    exp_q.delete();
    resp_lat = 1;
    run_insn(1'b1, 16'h0000, 16'h0000, 16'hFFFE, 8'h3C, 8'h00, 8'h00, 8'h46, 1'b0, ill, f, ip, to, dc);
    n_checks++;
    if (to || ill !== 1'b1 || f !== 8'h3C || ip !== 16'h0002 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL illegal_not_cb: got timeout=%b illegal=%b f=%h ip=%h left=%0d, expected timeout=0 illegal=1 f=3c ip=0002 left=0",
               to, ill, f, ip, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_start_ignored();
    logic ill; logic [7:0] f; logic [15:0] ip; logic to; int dc;
    resp_lat = 2;
    mem[16'h1010] = 8'h01;
    run_insn(1'b0, 16'h1000, 16'h0000, 16'h0500, 8'h00, 8'hCB, 8'h10, 8'h46, 1'b1, ill, f, ip, to, dc);
    n_checks++;
    if (to || ill !== 1'b0 || f !== 8'h10 || ip !== 16'h0504 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL start_while_busy: got timeout=%b illegal=%b f=%h ip=%h left=%0d, expected timeout=0 illegal=0 f=10 ip=0504 left=0",
               to, ill, f, ip, exp_q.size());
    end
    exp_q.delete();
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || mcyc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_while_busy_idle: got busy=%b valid=%b, expected 0 0", busy, mcyc_valid);
    end
  endtask

  task automatic test_reset_midflight();
    logic ill; logic [7:0] f; logic [15:0] ip; logic to; int dc;
    logic seen;
    resp_lat   = 0;
    stall_en   = 1'b1;
    stall_addr = 16'h1244;
    mem[16'h1244] = 8'hFE;
    mem[16'h0201] = 8'hCB;
    mem[16'h0202] = 8'h10;
    mem[16'h0203] = 8'h46;
    exp_q.push_back('{typ: CYCLE_M1,       wr: 1'b0, addr: 16'h0201, wdata: 8'h00, ext: 3'd0});
    exp_q.push_back('{typ: CYCLE_RDWR_MEM, wr: 1'b0, addr: 16'h0202, wdata: 8'h00, ext: 3'd0});
    exp_q.push_back('{typ: CYCLE_RDWR_MEM, wr: 1'b0, addr: 16'h0203, wdata: 8'h00, ext: 3'd2});
    @(posedge clk); #1;
    iy = 1'b0; reg_ix_in = 16'h1234; reg_ip_in = 16'h0200; reg_f_in = 8'h00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (mcyc_valid && mcyc_addr == 16'h1244) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midflight_rd_seen: got no RD at 1244, expected RD request");
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if ({mcyc_valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL midflight_reset: got valid/busy/done=%b, expected 000", {mcyc_valid, busy, done});
    end
    exp_q.delete();
    stall_en = 1'b0;
    @(posedge clk); #1;
    run_insn(1'b0, 16'h1234, 16'h0000, 16'h0200, 8'h00, 8'hCB, 8'h10, 8'h46, 1'b0, ill, f, ip, to, dc);
    n_checks++;
    if (to || ill !== 1'b0 || f !== 8'h54 || ip !== 16'h0204 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midflight_rerun: got timeout=%b illegal=%b f=%h ip=%h left=%0d, expected timeout=0 illegal=0 f=54 ip=0204 left=0",
               to, ill, f, ip, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic ill; logic [7:0] f; logic [15:0] ip; logic to; int dc;
    logic [7:0] ef;
`ifdef Z80_MEMPTR_FLAGS_EN
    ef = 8'h5D;
`else
    ef = 8'h55;
`endif
    resp_lat = 0;
    mem[16'h507F] = 8'h10;
    mem[16'h5FFF] = 8'h00;
    run_insn(1'b0, 16'h5000, 16'h6000, 16'h0600, 8'h44, 8'hCB, 8'h7F, 8'hC6, 1'b0, ill, f, ip, to, dc);
    n_checks++;
    if (to || ill !== 1'b0 || f !== 8'h44 || ip !== 16'h0604 || mem[16'h507F] !== 8'h11) begin
      n_fail++;
      $display("FAIL b2b_set0: got timeout=%b illegal=%b f=%h ip=%h mem=%h, expected timeout=0 illegal=0 f=44 ip=0604 mem=11",
               to, ill, f, ip, mem[16'h507F]);
    end
    run_insn(1'b1, 16'h5000, 16'h6000, 16'h0604, 8'h01, 8'hCB, 8'hFF, 8'h66, 1'b0, ill, f, ip, to, dc);
    n_checks++;
    if (to || ill !== 1'b0 || f !== ef || ip !== 16'h0608 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_bit4: got timeout=%b illegal=%b f=%h ip=%h left=%0d, expected timeout=0 illegal=0 f=%h ip=0608 left=0",
               to, ill, f, ip, exp_q.size(), ef);
    end
    exp_q.delete();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; last_resp_cyc = 0; resp_lat = 0;
    stall_en = 1'b0; stall_addr = 16'h0000;
    reset = 1'b1; start = 1'b0; iy = 1'b0;
    reg_ix_in = '0; reg_iy_in = '0; reg_f_in = '0; reg_ip_in = '0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    test_reset();
    test_bit_neg_disp();
    test_set_iy();
    test_res_wrap();
    test_bit_flags();
    test_illegal();
    test_start_ignored();
    test_reset_midflight();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test by 500000, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
